// File: rtl/datapath_sequencer.sv
// Control sequencer for the register-file/ALU datapath: accepts one instruction
// per handshake and drives Sel/Wen/WA/RAA/RAB/Op through execute and write-back.
// Optional macro SEQ_ILLEGAL_TRAP_EN: illegal ops enter a sticky TRAP state.
module datapath_sequencer #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [3:0]  Sel,
  output logic        Wen,
  output logic [3:0]  WA,
  output logic [3:0]  RAA,
  output logic [3:0]  RAB,
  output logic [2:0]  Op,
  input  logic        Flag,
  output logic        flag_q,
  output logic        done,
  output logic        skipped,
  output logic        busy
`ifdef SEQ_ILLEGAL_TRAP_EN
  ,
  output logic        trap
`endif
);

  localparam logic [2:0] OP_EQ   = 3'b010;
  localparam logic [2:0] OP_LOAD = 3'b101;
  localparam logic [3:0] LAST_CNT = 4'(EXEC_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_WRITE,
    S_CMP,
    S_TRAP
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       skip_q, skip_d;
  logic       flag_d;
  logic [2:0] op_q;
  logic [3:0] dest_q, srca_q, srcb_q;
  logic       accept;
  logic       op_legal;
  logic [3:0] sel_val;

  assign accept   = instr_valid & instr_ready;
  assign op_legal = (op_q <= OP_LOAD);
  assign sel_val  = (op_q == OP_LOAD) ? srca_q : 4'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      skip_q  <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      skip_q  <= skip_d;
      flag_q  <= flag_d;
    end
  end

  // Instruction fields are plain data: captured on handshake, never reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= instr[15:13];
      dest_q <= instr[12:9];
      srca_q <= instr[8:5];
      srcb_q <= instr[4:1];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    skip_d      = skip_q;
    flag_d      = flag_q;
    instr_ready = 1'b0;
    Sel         = 4'd0;
    Wen         = 1'b0;
    WA          = 4'd0;
    RAA         = 4'd0;
    RAB         = 4'd0;
    Op          = 3'd0;
    done        = 1'b0;
    skipped     = 1'b0;
    busy        = 1'b0;
`ifdef SEQ_ILLEGAL_TRAP_EN
    trap        = 1'b0;
`endif
    // Outputs hold reset values for the whole reset cycle.
    if (!rst) begin
      busy = (state_q != S_IDLE);
      case (state_q)
        S_IDLE: begin
          instr_ready = 1'b1;
          if (instr_valid) begin
            cnt_d  = 4'd0;
            skip_d = instr[0] & ~flag_q;
`ifdef SEQ_ILLEGAL_TRAP_EN
            if (instr[15:13] > OP_LOAD) state_d = S_TRAP;
            else
`endif
            if (instr[0] & ~flag_q) state_d = S_WRITE;
            else                    state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          Op  = op_q;
          RAA = srca_q;
          RAB = srcb_q;
          Sel = sel_val;
          if (cnt_q == LAST_CNT) state_d = (op_q == OP_EQ) ? S_CMP : S_WRITE;
          else                   cnt_d   = cnt_q + 4'd1;
        end
        S_WRITE: begin
          Op      = op_q;
          RAA     = srca_q;
          RAB     = srcb_q;
          Sel     = sel_val;
          WA      = dest_q;
          Wen     = ~skip_q & op_legal;
          done    = 1'b1;
          skipped = skip_q;
          state_d = S_IDLE;
        end
        S_CMP: begin
          Op      = op_q;
          RAA     = srca_q;
          RAB     = srcb_q;
          done    = 1'b1;
          flag_d  = Flag;
          state_d = S_IDLE;
        end
`ifdef SEQ_ILLEGAL_TRAP_EN
        S_TRAP: begin
          trap = 1'b1;
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Self-checking bench for datapath_sequencer: directed and random instructions
// checked cycle by cycle against a per-instruction timeline model.
module tb_datapath_sequencer;

  localparam int EXEC = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [3:0]  Sel, WA, RAA, RAB;
  logic        Wen;
  logic [2:0]  Op;
  logic        Flag;
  logic        flag_q, done, skipped, busy;
`ifdef SEQ_ILLEGAL_TRAP_EN
  logic        trap;
`endif

  int tests = 0;
  int fails = 0;
  logic mflag;

  datapath_sequencer #(.EXEC_CYCLES(EXEC)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .Sel(Sel), .Wen(Wen), .WA(WA), .RAA(RAA), .RAB(RAB), .Op(Op),
    .Flag(Flag), .flag_q(flag_q), .done(done), .skipped(skipped), .busy(busy)
`ifdef SEQ_ILLEGAL_TRAP_EN
    , .trap(trap)
`endif
  );

  always #5 clk = ~clk;

  logic [24:0] obs;
  assign obs = {instr_ready, Sel, Wen, WA, RAA, RAB, Op, flag_q, done, skipped, busy};

  function automatic logic [24:0] vec(input logic rdy, input logic [3:0] sel, input logic wen,
                                      input logic [3:0] wa, input logic [3:0] a, input logic [3:0] b,
                                      input logic [2:0] op, input logic fq, input logic dn,
                                      input logic sk, input logic bsy);
    return {rdy, sel, wen, wa, a, b, op, fq, dn, sk, bsy};
  endfunction

  function automatic logic [15:0] mk(input int op, input int d, input int a, input int b, input int c);
    return {3'(op), 4'(d), 4'(a), 4'(b), 1'(c)};
  endfunction

  task automatic chk(input string tag, input logic [24:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One instruction from its IDLE handshake to the next IDLE cycle.
  task automatic do_instr(input logic [15:0] ins, input logic fv);
    logic [2:0] op;
    logic [3:0] d, a, b, sel;
    logic       squash, legal;
    op = ins[15:13]; d = ins[12:9]; a = ins[8:5]; b = ins[4:1];
    squash = ins[0] & ~mflag;
    legal  = (op <= 3'd5);
    sel    = (op == 3'd5) ? a : 4'd0;
    chk("idle", vec(1, 0, 0, 0, 0, 0, 0, mflag, 0, 0, 0));
    instr = ins;
    instr_valid = 1'b1;
    step();
    instr = 16'($urandom);
    Flag = fv;
    if (squash) begin
      chk("squash_wb", vec(0, sel, 0, d, a, b, op, mflag, 1, 1, 1));
      step();
    end else begin
      for (int i = 0; i < EXEC; i++) begin
        chk("exec", vec(0, sel, 0, 0, a, b, op, mflag, 0, 0, 1));
        step();
      end
      if (op == 3'd2) begin
        chk("cmp", vec(0, 0, 0, 0, a, b, op, mflag, 1, 0, 1));
        step();
        mflag = fv;
      end else begin
        chk("wb", vec(0, sel, legal, d, a, b, op, mflag, 1, 0, 1));
        step();
      end
    end
    Flag = 1'($urandom);
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr = '0; Flag = 1'b0; mflag = 1'b0;
    step();
    step();
    chk("reset_cycle", vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    #1;
    chk("after_reset", vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    do_instr(mk(0, 3, 1, 2, 0), 1'b0);   // ADD
    do_instr(mk(2, 0, 4, 4, 0), 1'b1);   // EQ sets flag
    do_instr(mk(0, 6, 2, 3, 1), 1'b0);   // conditional ADD executes
    do_instr(mk(2, 0, 4, 5, 0), 1'b0);   // EQ clears flag
    do_instr(mk(4, 5, 8, 0, 1), 1'b0);   // conditional MOV squashed
    do_instr(mk(5, 7, 9, 0, 0), 1'b0);   // LOAD
    do_instr(mk(2, 0, 1, 1, 1), 1'b1);   // squashed EQ leaves flag
    do_instr(mk(1, 2, 3, 0, 0), 1'b0);   // SHR
`ifndef SEQ_ILLEGAL_TRAP_EN
    do_instr(mk(6, 4, 1, 2, 0), 1'b0);   // illegal retires as NOP
    do_instr(mk(7, 4, 1, 2, 0), 1'b0);
`endif

    // Reset during EXEC after flag was set
    do_instr(mk(2, 0, 7, 7, 0), 1'b1);
    chk("idle_pre_rst", vec(1, 0, 0, 0, 0, 0, 0, mflag, 0, 0, 0));
    instr = mk(0, 3, 1, 2, 0);
    step();
    chk("exec_pre_rst", vec(0, 0, 0, 0, 1, 2, 0, mflag, 0, 0, 1));
    rst = 1'b1;
    #1;
    chk("rst_in_exec", vec(0, 0, 0, 0, 0, 0, 0, mflag, 0, 0, 0));
    step();
    rst = 1'b0;
    mflag = 1'b0;
    #1;
    chk("idle_post_rst", vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    for (int n = 0; n < 40; n++) begin
`ifdef SEQ_ILLEGAL_TRAP_EN
      do_instr(mk($urandom_range(0, 5), $urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom_range(0, 15), $urandom_range(0, 1)), 1'($urandom));
`else
      do_instr(mk($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom_range(0, 15), $urandom_range(0, 1)), 1'($urandom));
`endif
    end

`ifdef SEQ_ILLEGAL_TRAP_EN
    chk("idle_pre_trap", vec(1, 0, 0, 0, 0, 0, 0, mflag, 0, 0, 0));
    instr = mk(6, 4, 1, 2, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      chk("trap_state", vec(0, 0, 0, 0, 0, 0, 0, mflag, 0, 0, 1));
      tests++;
      assert (trap === 1'b1) else begin
        fails++;
        $error("FAIL trap_flag observed=%b expected=1", trap);
      end
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    mflag = 1'b0;
    #1;
    chk("idle_post_trap", vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tests++;
    assert (trap === 1'b0) else begin
      fails++;
      $error("FAIL trap_clear observed=%b expected=0", trap);
    end
`endif

    instr_valid = 1'b0;
    step();
    chk("idle_end", vec(1, 0, 0, 0, 0, 0, 0, mflag, 0, 0, 0));
    step();
    chk("idle_end2", vec(1, 0, 0, 0, 0, 0, 0, mflag, 0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
Control-side counterpart of the register-file/ALU datapath. It accepts one instruction word at a time over a valid/ready handshake. It then sequences the datapath control lines (Sel, Wen, WA, RAA, RAB, Op) through execute and write-back cycles, and it captures the datapath's comparison Flag. It sits between the instruction source and the datapath, so that Wen is only ever asserted in a well-defined write-back cycle.

Parameters:
EXEC_CYCLES, 1, number of cycles Op/RAA/RAB are held with Wen=0 before write-back or compare (range 1..15)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
instr_valid  in  1  instruction word valid
instr_ready  out  1  sequencer can accept an instruction
instr  in  16  [15:13] op, [12:9] dest, [8:5] srcA, [4:1] srcB, [0] cond
Sel  out  4  InPort slice select (LOAD only)
Wen  out  1  register-file write enable
WA  out  4  write address
RAA  out  4  read address A
RAB  out  4  read address B
Op  out  3  ALU operation
Flag  in  1  datapath equality result
flag_q  out  1  last captured Flag
done  out  1  one-cycle pulse when an instruction retires
skipped  out  1  valid with done: instruction squashed by cond
busy  out  1  not IDLE

Behaviour:
- Op encoding:
  - 000 ADD, 001 SHR (A>>1), 010 EQ, 011 AND, 100 MOV (pass A), 101 LOAD (InPort slice selected by srcA).
  - 110 and 111 are illegal.
- Reset values: instr_ready=0 during the reset cycle, then 1. Sel, WA, RAA, RAB, Op = 0. Wen=0, flag_q=0, done=0, skipped=0, busy=0.
- States: IDLE, EXEC, WRITE, CMP, plus TRAP under the optional feature.
- IDLE:
  - instr_ready=1; all control outputs 0.
  - A handshake (instr_valid & instr_ready) at cycle T registers the fields and moves to EXEC at T+1.
  - If cond=1 and flag_q=0, the instruction is squashed: go to WRITE with Wen forced 0, skipped=1.
- EXEC:
  - Drives Op=op, RAA=srcA, RAB=srcB, Sel=srcA (LOAD) else 0; Wen=0, instr_ready=0.
  - A 4-bit counter holds EXEC for exactly EXEC_CYCLES cycles.
  - Then go to CMP if op=EQ, else WRITE.
- WRITE (one cycle):
  - Op/RAA/RAB/Sel held; WA=dest; Wen=1 unless squashed.
  - done=1; skipped as registered. Next state IDLE.
- CMP (one cycle):
  - Op/RAA/RAB held; Wen=0; done=1.
  - flag_q <= Flag at the end of the cycle. Next state IDLE.
- Latency: a non-EQ instruction accepted at T writes at T+EXEC_CYCLES+1. The next handshake is possible at T+EXEC_CYCLES+2.
- Illegal op (feature off): treated as NOP. It passes through EXEC, then WRITE with Wen=0, done=1, skipped=0.
- Wen is never 1 outside WRITE. Op/RAA/RAB are stable throughout EXEC..WRITE/CMP of one instruction.
- instr is ignored while instr_ready=0. A valid held across retirement is accepted on the first IDLE cycle.
- flag_q is modified only in CMP. Squashed EQ instructions do not update it.
- A reset asserted in any state: next cycle IDLE, all outputs at reset values, no done pulse, pending write abandoned.

Optional Feature:
Macro: SEQ_ILLEGAL_TRAP_EN.
- Defined: an illegal op moves from IDLE directly to TRAP at T+1, and the instruction does not retire (no done).
- TRAP is sticky until rst. In TRAP: output port trap=1, instr_ready=0, Wen=0, all controls 0.
- Not defined: no trap port; illegal ops retire as NOP as above.

Test Plan:
- EXEC_CYCLES=1, instr ADD dest=3 srcA=1 srcB=2 at T -> Op=000, RAA=1, RAB=2 at T+1. At T+2: Wen=1, WA=3, done=1. instr_ready=1 at T+3.
- EQ srcA=4 srcB=4 with Flag=1 during CMP -> Wen stays 0, done=1, flag_q=1 next cycle. Then ADD with cond=1 -> Wen=1 at write-back, skipped=0.
- flag_q=0, then MOV cond=1 dest=5 -> done=1 with skipped=1; Wen=0 for the whole instruction.
- EXEC_CYCLES=3, LOAD dest=7 srcA=9 -> Sel=9, Op=101 for 3 cycles with Wen=0; then exactly one Wen=1 cycle with WA=7.
- rst asserted during EXEC of an ADD -> next cycle IDLE, Wen=0, done=0, flag_q=0; no write occurs.
- op=110 with SEQ_ILLEGAL_TRAP_EN -> trap=1 from T+1 onward, instr_ready=0 until rst. Without the macro -> done=1, Wen=0.
